microcode_sequencer: RTL and testbench

Multi-step microprogram sequencer for the microcoded RISC-V core. It replaces the single-word-per-instruction ROM selection with a micro-PC (uPC) that walks a unified external micro-ROM. Each decoded instruction (class + sub-op) dispatches to an entry point. The block then issues one microcode word per cycle to the datapath under a valid/ready handshake, honouring next/done/jump/conditional-jump sequencing fields. It sits between instruction fetch/decode and the datapath control.

---
 rtl/microcode_sequencer.sv | 126 ++++++++++++
 tb/tb_microcode_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Micro-PC sequencer: dispatches decoded instructions into a unified micro-ROM and issues one word per cycle.
// Optional step watchdog enabled by defining MICROSEQ_WATCHDOG_EN.
module microcode_sequencer #(
  parameter int MICROCODE_WIDTH = 64,
  parameter int UPC_WIDTH       = 10,
  parameter int CLASS_WIDTH     = 3,
  parameter int SUBOP_WIDTH     = 4,
  parameter int MAX_STEPS       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [CLASS_WIDTH-1:0]     instr_class,
  input  logic [SUBOP_WIDTH-1:0]     instr_subop,
  output logic [UPC_WIDTH-1:0]       rom_addr,
  input  logic [MICROCODE_WIDTH-1:0] rom_data,
  input  logic                       cond_in,
  output logic                       uop_valid,
  input  logic                       uop_ready,
  output logic [MICROCODE_WIDTH-1:0] uop_word,
  output logic                       busy,
  output logic                       seq_error
);

  localparam logic [1:0] SEQ_NEXT  = 2'b00;
  localparam logic [1:0] SEQ_DONE  = 2'b01;
  localparam logic [1:0] SEQ_JUMP  = 2'b10;
  localparam logic [1:0] SEQ_CJUMP = 2'b11;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t                     state;
  logic [UPC_WIDTH-1:0]       upc;
  logic [UPC_WIDTH-1:0]       upc_inc;
  logic [UPC_WIDTH-1:0]       next_upc;
  logic [UPC_WIDTH-1:0]       target;
  logic [UPC_WIDTH-1:0]       entry;
  logic [1:0]                 seq;
  logic                       accept;
  logic                       load;
  logic                       vld_p1;
  logic [MICROCODE_WIDTH-1:0] uop_word_p1;

  assign instr_ready = (state == IDLE);
  assign busy        = (state == RUN);
  assign rom_addr    = upc;
  assign uop_valid   = vld_p1;
  assign uop_word    = uop_word_p1;

  assign seq     = rom_data[1:0];
  assign target  = rom_data[UPC_WIDTH+1:2];
  assign upc_inc = upc + UPC_WIDTH'(1);
  // Two words per op: the low bit of the entry is always zero.
  assign entry   = UPC_WIDTH'({instr_class, instr_subop, 1'b0});

  assign accept = instr_valid && (state == IDLE);
  assign load   = (state == RUN) && (!vld_p1 || uop_ready);

  always_comb begin
    next_upc = upc_inc;
    case (seq)
      SEQ_NEXT:  next_upc = upc_inc;
      SEQ_DONE:  next_upc = upc_inc;
      SEQ_JUMP:  next_upc = target;
      SEQ_CJUMP: next_upc = cond_in ? target : upc_inc;
      default:   next_upc = upc_inc;
    endcase
  end

`ifdef MICROSEQ_WATCHDOG_EN
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  logic [STEP_W-1:0] step_cnt;
  logic              seq_err_p1;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] c);
    return (c == STEP_W'(MAX_STEPS)) ? c : c + STEP_W'(1);
  endfunction

  assign seq_error = seq_err_p1;
`else
  assign seq_error = 1'b0;
`endif

  // Stage p1: issued micro-op register, advanced only on a load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      upc         <= '0;
      vld_p1      <= 1'b0;
      uop_word_p1 <= '0;
`ifdef MICROSEQ_WATCHDOG_EN
      step_cnt    <= '0;
      seq_err_p1  <= 1'b0;
`endif
    end else begin
`ifdef MICROSEQ_WATCHDOG_EN
      seq_err_p1 <= 1'b0;
`endif
      if (vld_p1 && uop_ready) vld_p1 <= 1'b0;
      if (accept) begin
        upc   <= entry;
        state <= RUN;
`ifdef MICROSEQ_WATCHDOG_EN
        step_cnt <= '0;
`endif
      end
      if (load) begin
        uop_word_p1 <= rom_data;
        vld_p1      <= 1'b1;
        upc         <= next_upc;
        if (seq == SEQ_DONE) state <= IDLE;
`ifdef MICROSEQ_WATCHDOG_EN
        step_cnt <= sat_inc(step_cnt);
        // The word that hits the limit is still issued; the program is abandoned after it.
        if ((seq != SEQ_DONE) && (sat_inc(step_cnt) == STEP_W'(MAX_STEPS))) begin
          state      <= IDLE;
          seq_err_p1 <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed timing scenarios plus randomized
// instruction streams compared against a ROM-walking reference model.
module tb_microcode_sequencer;
  localparam int MW = 64;
  localparam int UW = 10;
  localparam int CW = 3;
  localparam int SW = 4;
  localparam int MAX_STEPS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [CW-1:0] cls;
  logic [SW-1:0] sub;
  logic [UW-1:0] rom_addr;
  logic [MW-1:0] rom_data;
  logic          cond_in;
  logic          uop_valid;
  logic          uop_ready;
  logic [MW-1:0] uop_word;
  logic          busy;
  logic          seq_error;

  logic [MW-1:0] rom [0:1023];
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] got_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_class(cls), .instr_subop(sub), .rom_addr(rom_addr), .rom_data(rom_data),
    .cond_in(cond_in), .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_word(uop_word),
    .busy(busy), .seq_error(seq_error)
  );

  function automatic logic [MW-1:0] mk(input logic [1:0] s, input int tgt);
    logic [MW-1:0] w;
    w = {$urandom, $urandom};
    w[11:2] = tgt[9:0];
    w[1:0] = s;
    return w;
  endfunction

  // Random ROM whose programs always terminate: lower region jumps upward, upper region only forward.
  task automatic gen_rom();
    for (int a = 0; a < 1024; a++) begin
      int r;
      r = $urandom_range(0, 3);
      if (a < 256) begin
        if (a % 2 == 0) begin
          case (r)
            0: rom[a] = mk(2'b00, 0);
            1: rom[a] = mk(2'b01, 0);
            2: rom[a] = mk(2'b10, $urandom_range(256, 1023));
            default: rom[a] = mk(2'b11, $urandom_range(256, 1023));
          endcase
        end else begin
          rom[a] = (r < 2) ? mk(2'b01, 0) : mk(2'b10, $urandom_range(256, 1023));
        end
      end else if (a == 1023) begin
        rom[a] = mk(2'b01, 0);
      end else begin
        case (r)
          0: rom[a] = mk(2'b01, 0);
          1: rom[a] = mk(2'b00, 0);
          2: rom[a] = mk(2'b10, $urandom_range(a + 1, 1023));
          default: rom[a] = mk(2'b11, $urandom_range(a + 1, 1023));
        endcase
      end
    end
  endtask

  // Reference: walk the ROM from the entry point, appending each issued word; returns 1 on watchdog abort.
  function automatic int expect_seq(input int c_cls, input int c_sub, input bit c);
    int upc;
    int steps;
    logic [MW-1:0] w;
    upc = c_cls * 32 + c_sub * 2;
    steps = 0;
    while (1) begin
      w = rom[upc];
      exp_q.push_back(w);
      steps++;
      if (w[1:0] == 2'b01) return 0;
`ifdef MICROSEQ_WATCHDOG_EN
      if (steps == MAX_STEPS) return 1;
`endif
      if (steps > 4096) return 0;
      if (w[1:0] == 2'b10 || (w[1:0] == 2'b11 && c)) upc = int'(w[11:2]);
      else upc = (upc + 1) % 1024;
    end
    return 0;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1) $display("FAIL rst_instr_ready: got %b want 1", instr_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (uop_valid !== 1'b0) $display("FAIL rst_uop_valid: got %b want 0", uop_valid); else n_pass++;
    n_checks++; if (uop_word !== '0) $display("FAIL rst_uop_word: got %h want 0", uop_word); else n_pass++;
    n_checks++; if (seq_error !== 1'b0) $display("FAIL rst_seq_error: got %b want 0", seq_error); else n_pass++;
    n_checks++; if (rom_addr !== 10'h000) $display("FAIL rst_rom_addr: got %h want 000", rom_addr); else n_pass++;
    rom[10'h2A] = mk(2'b00, 0);
    rom[10'h2B] = mk(2'b01, 0);
    uop_ready = 1'b0;
    instr_valid = 1'b1; cls = 3'd1; sub = 4'd5;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (uop_valid !== 1'b1) $display("FAIL rst_setup_valid: got %b want 1", uop_valid); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (uop_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", uop_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (uop_word !== '0) $display("FAIL rst_async_word: got %h want 0", uop_word); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", instr_ready); else n_pass++;
  endtask

  task automatic test_single_uop();
    rom[10'h006] = mk(2'b01, 0);
    uop_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1) $display("FAIL single_ready_pre: got %b want 1", instr_ready); else n_pass++;
    instr_valid = 1'b1; cls = 3'd0; sub = 4'd3;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (rom_addr !== 10'h006) $display("FAIL single_rom_addr: got %h want 006", rom_addr); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (uop_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", uop_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", uop_valid); else n_pass++;
    n_checks++; if (uop_word !== rom[6]) $display("FAIL single_word: got %h want %h", uop_word, rom[6]); else n_pass++;
    n_checks++; if (busy !== 1'b0 || instr_ready !== 1'b1) $display("FAIL single_idle: got busy %b ready %b want 0 1", busy, instr_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", uop_valid); else n_pass++;
  endtask

  task automatic test_jump_stall();
    rom[10'h020] = mk(2'b00, 0);
    rom[10'h021] = mk(2'b10, 10'h300);
    rom[10'h300] = mk(2'b01, 0);
    uop_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b1; cls = 3'd1; sub = 4'd0;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (rom_addr !== 10'h020) $display("FAIL js_entry: got %h want 020", rom_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_word !== rom[10'h020]) $display("FAIL js_uop1: got %h want %h", uop_word, rom[10'h020]); else n_pass++;
    n_checks++; if (rom_addr !== 10'h021) $display("FAIL js_addr1: got %h want 021", rom_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_word !== rom[10'h021]) $display("FAIL js_uop2: got %h want %h", uop_word, rom[10'h021]); else n_pass++;
    uop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (uop_valid !== 1'b1 || uop_word !== rom[10'h021]) $display("FAIL js_hold%0d: got %b %h want 1 %h", i, uop_valid, uop_word, rom[10'h021]); else n_pass++;
      n_checks++; if (rom_addr !== 10'h300 || busy !== 1'b1) $display("FAIL js_stall_addr%0d: got %h busy %b want 300 1", i, rom_addr, busy); else n_pass++;
    end
    uop_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (uop_word !== rom[10'h300]) $display("FAIL js_uop3: got %h want %h", uop_word, rom[10'h300]); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL js_done_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_valid !== 1'b0) $display("FAIL js_drain: got %b want 0", uop_valid); else n_pass++;
  endtask

  task automatic test_conditional();
    rom[10'h040] = mk(2'b11, 10'h200);
    rom[10'h041] = mk(2'b01, 0);
    rom[10'h200] = mk(2'b01, 0);
    uop_ready = 1'b1;
    for (int c = 1; c >= 0; c--) begin
      int want;
      want = (c == 1) ? 10'h200 : 10'h041;
      cond_in = c[0];
      @(negedge clk);
      instr_valid = 1'b1; cls = 3'd2; sub = 4'd0;
      @(negedge clk);
      instr_valid = 1'b0;
      n_checks++; if (rom_addr !== 10'h040) $display("FAIL cj_entry_c%0d: got %h want 040", c, rom_addr); else n_pass++;
      @(negedge clk);
      n_checks++; if (uop_word !== rom[10'h040]) $display("FAIL cj_uop1_c%0d: got %h want %h", c, uop_word, rom[10'h040]); else n_pass++;
      n_checks++; if (rom_addr !== want[9:0]) $display("FAIL cj_target_c%0d: got %h want %h", c, rom_addr, want[9:0]); else n_pass++;
      @(negedge clk);
      n_checks++; if (uop_word !== rom[want]) $display("FAIL cj_uop2_c%0d: got %h want %h", c, uop_word, rom[want]); else n_pass++;
      @(negedge clk);
      n_checks++; if (uop_valid !== 1'b0) $display("FAIL cj_drain_c%0d: got %b want 0", c, uop_valid); else n_pass++;
    end
    cond_in = 1'b0;
  endtask

  task automatic test_wrap();
    rom[10'h062] = mk(2'b10, 10'h3FF);
    rom[10'h3FF] = mk(2'b00, 0);
    rom[10'h000] = mk(2'b01, 0);
    uop_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b1; cls = 3'd3; sub = 4'd1;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (rom_addr !== 10'h062) $display("FAIL wrap_entry: got %h want 062", rom_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (rom_addr !== 10'h3FF) $display("FAIL wrap_jump: got %h want 3ff", rom_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_word !== rom[10'h3FF]) $display("FAIL wrap_uop2: got %h want %h", uop_word, rom[10'h3FF]); else n_pass++;
    n_checks++; if (rom_addr !== 10'h000) $display("FAIL wrap_addr: got %h want 000", rom_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_word !== rom[10'h000]) $display("FAIL wrap_uop3: got %h want %h", uop_word, rom[10'h000]); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_valid !== 1'b0 || instr_ready !== 1'b1) $display("FAIL wrap_idle: got valid %b ready %b want 0 1", uop_valid, instr_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    rom[10'h006] = mk(2'b01, 0);
    rom[10'h00A] = mk(2'b01, 0);
    uop_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1; cls = 3'd0; sub = 4'd3;
    @(negedge clk);
    sub = 4'd5;
    @(negedge clk);
    n_checks++; if (uop_word !== rom[10'h006] || instr_ready !== 1'b1) $display("FAIL b2b_first: got %h ready %b want %h 1", uop_word, instr_ready, rom[10'h006]); else n_pass++;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || rom_addr !== 10'h00A) $display("FAIL b2b_accept: got busy %b addr %h want 1 00a", busy, rom_addr); else n_pass++;
    n_checks++; if (uop_word !== rom[10'h006]) $display("FAIL b2b_wait: got %h want %h", uop_word, rom[10'h006]); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_word !== rom[10'h006] || uop_valid !== 1'b1) $display("FAIL b2b_hold: got %b %h want 1 %h", uop_valid, uop_word, rom[10'h006]); else n_pass++;
    uop_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (uop_word !== rom[10'h00A] || uop_valid !== 1'b1) $display("FAIL b2b_second: got %b %h want 1 %h", uop_valid, uop_word, rom[10'h00A]); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (uop_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", uop_valid); else n_pass++;
  endtask

  task automatic test_watchdog();
    int got;
    int errc;
    int err_busy;
    rom[10'h080] = mk(2'b10, 10'h100);
    rom[10'h100] = mk(2'b10, 10'h100);
    uop_ready = 1'b1;
    got = 0; errc = 0; err_busy = 0;
    @(negedge clk);
    instr_valid = 1'b1; cls = 3'd4; sub = 4'd0;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uop_valid) got++;
      if (seq_error) begin
        errc++;
        if (busy) err_busy++;
      end
    end
`ifdef MICROSEQ_WATCHDOG_EN
    n_checks++; if (got !== MAX_STEPS) $display("FAIL wd_uops: got %0d want %0d", got, MAX_STEPS); else n_pass++;
    n_checks++; if (errc !== 1) $display("FAIL wd_pulse: got %0d cycles want 1", errc); else n_pass++;
    n_checks++; if (err_busy !== 0) $display("FAIL wd_idle_at_pulse: got %0d want 0", err_busy); else n_pass++;
    n_checks++; if (busy !== 1'b0 || instr_ready !== 1'b1) $display("FAIL wd_end_idle: got busy %b ready %b want 0 1", busy, instr_ready); else n_pass++;
`else
    n_checks++; if (got !== 40) $display("FAIL wd_runaway_uops: got %0d want 40", got); else n_pass++;
    n_checks++; if (errc !== 0) $display("FAIL wd_no_error: got %0d want 0", errc); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wd_still_busy: got %b want 1", busy); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1 || uop_valid !== 1'b0) $display("FAIL wd_recover: got ready %b valid %b want 1 0", instr_ready, uop_valid); else n_pass++;
`endif
  endtask

  task automatic run_stream(input int n, input int ready_pct);
    int cl[$];
    int sb[$];
    int idx;
    int guard;
    int exp_err;
    int errs;
    bit hold;
    bit c;
    logic [MW-1:0] held;
    exp_q.delete();
    got_q.delete();
    c = $urandom_range(0, 1);
    cond_in = c;
    exp_err = 0;
    for (int i = 0; i < n; i++) begin
      cl.push_back($urandom_range(0, 7));
      sb.push_back($urandom_range(0, 15));
      exp_err += expect_seq(cl[i], sb[i], c);
    end
    idx = 0; guard = 0; errs = 0; hold = 0; held = '0;
    while (1) begin
      @(negedge clk);
      if (hold) begin
        n_checks++;
        if (uop_valid !== 1'b1 || uop_word !== held) $display("FAIL stream_stable: got %b %h want 1 %h", uop_valid, uop_word, held); else n_pass++;
      end
      if (seq_error) errs++;
      if (idx == n && !busy && !uop_valid && instr_ready) break;
      guard++;
      if (guard > 5000) begin
        n_checks++;
        $display("FAIL stream_timeout: got %0d of %0d instructions issued", idx, n);
        break;
      end
      instr_valid = (idx < n);
      if (idx < n) begin
        cls = cl[idx][CW-1:0];
        sub = sb[idx][SW-1:0];
        if (instr_ready) idx++;
      end
      uop_ready = ($urandom_range(0, 99) < ready_pct);
      if (uop_valid && uop_ready) got_q.push_back(uop_word);
      hold = uop_valid && !uop_ready;
      held = uop_word;
    end
    instr_valid = 1'b0;
    uop_ready = 1'b1;
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL stream_count: got %0d uops want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL stream_uop%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (errs !== exp_err) $display("FAIL stream_seq_error: got %0d pulses want %0d", errs, exp_err); else n_pass++;
  endtask

  task automatic test_random_stream();
    gen_rom();
    run_stream(30, 100);
    run_stream(30, 60);
    gen_rom();
    run_stream(30, 35);
    run_stream(30, 85);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    cls = '0;
    sub = '0;
    cond_in = 1'b0;
    uop_ready = 1'b0;
    gen_rom();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_uop();
    test_jump_stall();
    test_conditional();
    test_wrap();
    test_back_to_back();
    test_watchdog();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
